// File: rtl/pi_screen_pkg.sv
// Shared definitions for the pi digit screen path: blank code, default
// geometry and the row-fetch state encoding.
package pi_screen_pkg;

   localparam logic [3:0]  PI_BLANK_DIGIT = 4'hF;
   localparam int unsigned PI_N           = 17;
   localparam int unsigned PI_COLS        = 80;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      DONE
   } fetch_state_e;

endpackage

// File: rtl/pi_row_buf.sv
// Ping-pong row buffer: two halves of COLS 4-bit digits. The writer always
// targets the back half; the renderer reads the front half through a
// registered port. Each half carries a valid flag; an invalid front reads
// as blank.
module pi_row_buf
   import pi_screen_pkg::*;
#(
   parameter int unsigned COLS  = PI_COLS,
   parameter int unsigned COL_W = $clog2(COLS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [COL_W-1:0] wr_col,
   input  logic [3:0]       wr_data,
   input  logic             toggle,
   input  logic             set_back_valid,
   input  logic [COL_W-1:0] rd_col,
   output logic [3:0]       rd_digit
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

   logic [3:0] mem_q [2][COLS];
   logic       front_q, front_d;
   logic [1:0] valid_q, valid_d;
   logic [3:0] rd_digit_q, rd_digit_d;
   logic       back;

   assign back = ~front_q;

   // Front select and per-half valid flags; a toggle hands the old front
   // back to the writer, so it is invalidated on the way out.
   always_comb begin
      front_d = front_q;
      valid_d = valid_q;
      if (set_back_valid) begin
         valid_d[back] = 1'b1;
      end
      if (toggle) begin
         front_d          = ~front_q;
         valid_d[front_q] = 1'b0;
      end
   end

   // Registered read of the front half; out-of-row columns read blank.
   always_comb begin
      rd_digit_d = PI_BLANK_DIGIT;
      if (valid_q[front_q] && (rd_col <= LAST_COL)) begin
         rd_digit_d = mem_q[front_q][rd_col];
      end
   end

   // Digit storage is left uncleared; validity is tracked by the flags.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[back][wr_col] <= wr_data;
      end
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         front_q    <= 1'b0;
         valid_q    <= '0;
         rd_digit_q <= PI_BLANK_DIGIT;
      end else begin
         front_q    <= front_d;
         valid_q    <= valid_d;
         rd_digit_q <= rd_digit_d;
      end
   end

   assign rd_digit = rd_digit_q;

endmodule

// File: rtl/pi_row_fetch.sv
// Row prefetcher for the pi digit screen. Walks pi_index across one text
// row, holds each index until pi_get_digit has settled, and writes the
// digit into the back half of a ping-pong buffer read by the renderer.
// Optional: define PI_ROW_FETCH_UNDERRUN_CNT_EN to add a saturating
// underrun_cnt output counting swaps that arrive before a row is ready.
module pi_row_fetch
   import pi_screen_pkg::*;
#(
   parameter int unsigned N         = PI_N,
   parameter int unsigned COLS      = PI_COLS,
   parameter int unsigned COL_W     = $clog2(COLS),
   parameter int unsigned HOLD      = 12,
   parameter int unsigned MAX_INDEX = 100000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             row_req,
   input  logic [N-1:0]     row_first,
   output logic [N-1:0]     pi_index,
   input  logic [3:0]       pi_digit,
   output logic             busy,
   output logic             row_ready,
   input  logic             swap,
   input  logic [COL_W-1:0] rd_col,
   output logic [3:0]       rd_digit
`ifdef PI_ROW_FETCH_UNDERRUN_CNT_EN
   ,
   output logic [15:0]      underrun_cnt
`endif
);

   localparam int unsigned      HC_W      = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD - 1);
   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
   localparam logic [N:0]       MAX_IDX   = (N + 1)'(MAX_INDEX);

   fetch_state_e     state_q, state_d;
   logic [N-1:0]     base_q, base_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [HC_W-1:0]  hold_q, hold_d;
   logic [N-1:0]     pi_index_q, pi_index_d;
   logic             busy_q, busy_d;
   logic             row_ready_q, row_ready_d;

   logic [N:0]       sum_w;
   logic [N-1:0]     next_index;
   logic             in_range;
   logic             swap_take;
   logic             advance;

   logic             wr_en;
   logic [COL_W-1:0] wr_col;
   logic [3:0]       wr_data;
   logic             buf_set_valid;

   // Extra carry bit so an index past 2^N lands out of range instead of
   // wrapping back to a low, stored index.
   assign sum_w      = {1'b0, base_q} + (N + 1)'(col_q);
   assign next_index = sum_w[N-1:0] + N'(1);
   assign in_range   = (sum_w < MAX_IDX);
   assign swap_take  = swap && row_ready_q;

   // Next-state logic. A swap taken in IDLE frees the back half in the same
   // cycle, so a coincident row_req is accepted into it.
   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      col_d         = col_q;
      hold_d        = hold_q;
      pi_index_d    = pi_index_q;
      busy_d        = busy_q;
      row_ready_d   = row_ready_q;
      wr_en         = 1'b0;
      wr_col        = col_q;
      wr_data       = pi_digit;
      buf_set_valid = 1'b0;
      advance       = 1'b0;

      if (swap_take) begin
         row_ready_d = 1'b0;
      end

      case (state_q)
         IDLE: begin
            if (row_req && (!row_ready_q || swap_take)) begin
               base_d     = row_first;
               col_d      = '0;
               hold_d     = '0;
               pi_index_d = row_first;
               busy_d     = 1'b1;
               state_d    = SETTLE;
            end
         end
         SETTLE: begin
            if (!in_range) begin
               wr_en   = 1'b1;
               wr_data = PI_BLANK_DIGIT;
               advance = 1'b1;
            end else if (hold_q == HOLD_LAST) begin
               hold_d  = '0;
               state_d = CAPTURE;
            end else begin
               hold_d = hold_q + HC_W'(1);
            end
         end
         CAPTURE: begin
            wr_en   = 1'b1;
            advance = 1'b1;
         end
         DONE: begin
            row_ready_d   = 1'b1;
            buf_set_valid = 1'b1;
            state_d       = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Column step shared by the blank fast path and the normal capture.
      if (advance) begin
         if (col_q == LAST_COL) begin
            busy_d  = 1'b0;
            state_d = DONE;
         end else begin
            col_d      = col_q + COL_W'(1);
            hold_d     = '0;
            pi_index_d = next_index;
            state_d    = SETTLE;
         end
      end
   end

   // FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         base_q      <= '0;
         col_q       <= '0;
         hold_q      <= '0;
         pi_index_q  <= '0;
         busy_q      <= 1'b0;
         row_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         col_q       <= col_d;
         hold_q      <= hold_d;
         pi_index_q  <= pi_index_d;
         busy_q      <= busy_d;
         row_ready_q <= row_ready_d;
      end
   end

`ifdef PI_ROW_FETCH_UNDERRUN_CNT_EN
   logic [15:0] underrun_q, underrun_d;

   // Count swaps that find no completed row, saturating at all-ones.
   always_comb begin
      underrun_d = underrun_q;
      if (swap && !row_ready_q && (underrun_q != '1)) begin
         underrun_d = underrun_q + 16'd1;
      end
   end

   // Underrun counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         underrun_q <= '0;
      end else begin
         underrun_q <= underrun_d;
      end
   end

   assign underrun_cnt = underrun_q;
`endif

   pi_row_buf #(
      .COLS  (COLS),
      .COL_W (COL_W)
   ) u_buf (
      .clk            (clk),
      .rst            (rst),
      .wr_en          (wr_en),
      .wr_col         (wr_col),
      .wr_data        (wr_data),
      .toggle         (swap_take),
      .set_back_valid (buf_set_valid),
      .rd_col         (rd_col),
      .rd_digit       (rd_digit)
   );

   assign pi_index  = pi_index_q;
   assign busy      = busy_q;
   assign row_ready = row_ready_q;

endmodule

// File: doc/pi_row_fetch.md
Name: pi_row_fetch

Overview:
- Sits directly upstream of pi_get_digit and feeds it.
- Drives pi_index and samples the returned BCD digit once that unit's fixed pipeline has settled.
- Fills one text row of digits into a ping-pong line buffer; the screen renderer reads the other half at one random-access read per clock.
- A row prefetch runs during the current row's display; the renderer swaps halves at row boundary.

Parameters:
- N, 17, pi_index width (matches pi_get_digit).
- COLS, 80, digits per row.
- COL_W, $clog2(COLS), column index width.
- HOLD, 12, cycles pi_index is held before pi_digit is sampled. Must be >= pi_get_digit worst-case latency, which is 4-phase plus pipeline, so HOLD >= 10.
- MAX_INDEX, 100000, first index with no stored digit; such cells fill with the blank code.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- row_req  in  1  pulse: start fetching a row into the back buffer
- row_first  in  N  index of the row's first digit; sampled on the accepted row_req
- pi_index  out  N  index to pi_get_digit
- pi_digit  in  4  BCD digit from pi_get_digit
- busy  out  1  fetch in progress
- row_ready  out  1  back buffer complete, awaiting swap (level)
- swap  in  1  pulse at renderer row boundary
- rd_col  in  COL_W  renderer read column
- rd_digit  out  4  registered front-buffer digit for rd_col (1-cycle latency); 4'hF = blank

Behaviour:
- Reset values: pi_index=0, busy=0, row_ready=0, rd_digit=4'hF, front select=0. Both buffers are not cleared, but a valid flag per half resets to 0. Reading an invalid front half returns 4'hF.
- FSM states:
  - IDLE
    - row_req && !row_ready: latch base=row_first, col=0; go to SETTLE.
    - row_req while row_ready=1 or busy=1: ignored.
  - SETTLE
    - pi_index = base+col; hold counter runs 0..HOLD-1.
    - At HOLD-1, go to CAPTURE.
    - If base+col >= MAX_INDEX: skip the hold, write 4'hF, take 1 cycle.
  - CAPTURE
    - Write pi_digit to back[col].
    - If col==COLS-1, go to DONE; else col++ and go to SETTLE.
  - DONE
    - Set row_ready=1, back-half valid=1; go to IDLE.
- Row fetch time: COLS*(HOLD+1) cycles when all indices are in range. Defaults give 1040 cycles, which is below an 800-wide line period × font height.
- swap:
  - With row_ready=1: toggle front select next cycle, clear row_ready, invalidate the new back half.
  - With row_ready=0: no toggle; the front buffer is re-displayed (underrun).
- swap and DONE in the same cycle: DONE wins. row_ready is set, and the swap is treated as an underrun. The next swap performs the toggle.
- swap and row_req in the same cycle with row_ready=1: the swap is applied first, and row_req is accepted into the freshly freed half.
- Index arithmetic:
  - base+col is computed in N+1 bits.
  - Overflow past 2^N counts as >= MAX_INDEX, so it yields blank. There is no wrap to index 0.
- rd_col >= COLS: rd_digit=4'hF.
- pi_index is stable for the whole SETTLE span and changes only on entry to SETTLE.
- rst mid-fetch: returns to IDLE within 1 cycle, drops busy, and invalidates both halves.

Optional Feature:
- Macro: PI_ROW_FETCH_UNDERRUN_CNT_EN
- Enabled:
  - Adds output underrun_cnt [15:0], reset to 0.
  - Increments on each swap with row_ready=0.
  - Saturates at 16'hFFFF.
- Disabled: no port and no counter logic. Behaviour is otherwise identical.

Decomposition:
- Shared package pi_screen_pkg holds:
  - PI_BLANK_DIGIT=4'hF
  - default N and COLS
  - FSM state enum (IDLE, SETTLE, CAPTURE, DONE)
- Sub-module: pi_row_buf, a ping-pong 2×COLS×4 RAM with a sync write port, a registered read port and front select. The FSM stays in pi_row_fetch.

Test Plan:
1. Index sequencing: reset; row_first=0, row_req. Drive a model pi_get_digit (digit = 3,1,4,1,5,9,… by index, latency 9). The bench then:
   - expects busy for 80×13=1040 cycles, then row_ready=1;
   - swaps;
   - expects rd_col=0..5 to give 3,1,4,1,5,9.
2. Hold check: the model returns 4'h0 for fewer than 9 cycles after an index change. The bench expects no 0 captured and pi_index stable 12 cycles per column.
3. MAX_INDEX boundary: row_first=99990. The bench expects columns 0..9 = model digits, columns 10..79 = 4'hF, and fetch time 10×13+70 cycles.
4. Underrun:
   - swap before row_ready: front unchanged, underrun_cnt=1 (macro on);
   - swap after row_ready: toggle occurs.
   - DONE coinciding with swap gives row_ready=1 with no toggle.
5. Reset mid-fetch: rst at column 40. The bench expects busy=0 next cycle, rd_digit=4'hF for all columns, and that a new row_req restarts at column 0.
6. Back-to-back: row_req ignored while row_ready=1. A swap with a simultaneous row_req starts a fetch into the freed half.
